wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage core. Sits directly downstream of the memory stage and consumes its `mem_stage_out_t` bundle through a valid/ready handshake backed by a two-entry (main + skid) buffer. Selects the writeback value, drives the register-file write port, exports forwarding data for the hazard unit, and counts retired instructions.

## Interface
Parameters:
- `INSTRET_W`, 64, width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  memory stage presents a valid `mem_stage_out_t`.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_data`  in  `mem_stage_out_t`  opr_res, dmem_rdata, lsu_rdata, rd, rf_en, wb_sel.
- `wb_stall`  in  1  hold the head entry; RF write port unavailable this cycle.
- `flush`  in  1  discard all buffered entries.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `fwd_en`  out  1  head entry will write RF (forwarding valid).
- `fwd_rd`  out  5  forwarding destination register.
- `fwd_data`  out  32  forwarding value.
- `instret`  out  `INSTRET_W`  retired-instruction count.

## Operation
- Storage: `main` entry (head, drives outputs) and `skid` entry, each with a valid bit.
- Accept: `in_valid && in_ready` at a rising edge. Entry goes to `main` if `main` is empty or retiring that edge, otherwise to `skid`.
- Retire: `main` valid and `!wb_stall` at a rising edge. `skid` (if valid) moves to `main` on the same edge. A simultaneous accept then goes to `skid`.
- `in_ready` = `!skid_valid`, registered. No combinational path from `wb_stall` or `in_valid`.
- Writeback select on `main.wb_sel`: `WB_ALU` (2'b00) → opr_res; `WB_MEM` (2'b01) → lsu_rdata; `WB_PC4` (2'b10) → opr_res, because PC+4 is precomputed upstream; 2'b11 → opr_res. `dmem_rdata` is not used for the write value.
- Effective write enable = `main_valid && main.rf_en && (main.rd != 0)`.
- Outputs:
  - `rf_we` = effective write enable && `!wb_stall`.
  - `fwd_en` = effective write enable, independent of stall.
  - `rf_waddr`/`fwd_rd` = `main.rd`; `rf_wdata`/`fwd_data` = selected value.
- `instret` increments by 1 on every retire, including entries with `rf_en=0` or `rd=0`. It wraps modulo 2^`INSTRET_W`.
- Flush: clears both valid bits at the edge. Flush wins over a simultaneous accept, which is dropped, and over a simultaneous retire, which does not count. The `instret` value is preserved.

## Timing
- Latency: accept at edge N → visible on `rf_*`/`fwd_*` during cycle N+1; RF write at edge N+1 if unstalled.
- Throughput: one entry per cycle when `wb_stall=0`.
- Full: both entries valid → `in_ready=0` from the next cycle. `in_valid` may remain high and must hold `in_data` stable.
- Reset (async, any time, including mid-stall with both entries full): all valid bits 0, `instret`=0, `in_ready`=1, `rf_we`=0, `fwd_en`=0, `rf_waddr`/`fwd_rd`=0, `rf_wdata`/`fwd_data`=0. Payload registers reset to 0.
- Without reset, `rf_*`/`fwd_*` payload is 0 whenever `main` is empty (muxed, not left stale).

## Structure
- New package `wb_stage_pkg`:
  - `wb_sel_e` constants `WB_ALU`, `WB_MEM`, `WB_PC4`.
  - `wb_stage_out_t` struct: we, waddr, wdata.
- `wb_stage` imports `mem_stage_pkg` for `mem_stage_out_t`.
- One sub-module, `wb_skid_buf`: generic two-entry valid/ready buffer with flush, parameterised on payload type. Select, enable and counter logic stay in `wb_stage`.

## Test plan
- Single load: accept {rd=5, rf_en=1, wb_sel=01, lsu_rdata=0xDEADBEEF} → next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, `instret`=1 afterwards.
- x0 suppression: accept {rd=0, rf_en=1, opr_res=0x1234} → `rf_we=0`, `fwd_en=0`, `instret` still increments to 1.
- Back-to-back 4 entries, `wb_stall` high 2 cycles after the first → `in_ready` drops after the skid fills. All 4 writes appear in order with correct data. `instret`=4.
- Stall with forwarding: `main` holds rd=7, value 0x10 with `wb_stall=1` → `fwd_en=1`, `fwd_rd=7`, `fwd_data=0x10`, `rf_we=0` until stall releases.
- Flush with both entries full plus a simultaneous accept → next cycle no valid entries, `in_ready=1`, `rf_we=0`, `instret` unchanged.
- Async reset asserted mid-cycle with `instret`=3 → outputs zero immediately without waiting for a clock edge. After release, `in_ready=1`, `instret`=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Memory-stage output bundle consumed by the writeback stage.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [XLEN-1:0]   opr_res;
    logic [XLEN-1:0]   dmem_rdata;
    logic [XLEN-1:0]   lsu_rdata;
    logic [REG_AW-1:0] rd;
    logic              rf_en;
    logic [1:0]        wb_sel;
  } mem_stage_out_t;

endpackage

// File: rtl/wb_stage_pkg.sv
// Writeback-stage select encoding and register-file write bundle.
package wb_stage_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
  } wb_stage_out_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry (main + skid) valid/ready buffer with flush; main is the head.
module wb_skid_buf #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic ready_q, ready_d;

  logic accept;
  logic retire;

  assign accept = in_valid_i && ready_q;
  assign retire = main_valid_q && out_ready_i;

  // Skid drains into main whenever main frees up; new data lands behind it.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (retire || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = in_data_i;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_data_i;
      end
    end else if (accept) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers memory-stage results, drives the RF write port,
// exports forwarding data and counts retired instructions.
module wb_stage
  import mem_stage_pkg::*;
  import wb_stage_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  mem_stage_out_t       in_data,
  input  logic                 wb_stall,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 fwd_en,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data,
  output logic [INSTRET_W-1:0] instret
);

  logic                 main_valid;
  mem_stage_out_t       main_data;
  wb_stage_out_t        wb_out;
  logic                 retire;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 unused_dmem;

  wb_skid_buf #(
    .T (mem_stage_out_t)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (main_valid),
    .out_ready_i (!wb_stall),
    .out_data_o  (main_data)
  );

  // PC+4 arrives precomputed in opr_res; raw dmem_rdata never reaches the RF.
  always_comb begin
    wb_out = '0;
    if (main_valid) begin
      wb_out.we    = main_data.rf_en && (main_data.rd != 5'd0);
      wb_out.waddr = main_data.rd;
      case (wb_sel_e'(main_data.wb_sel))
        WB_MEM:         wb_out.wdata = main_data.lsu_rdata;
        WB_ALU, WB_PC4: wb_out.wdata = main_data.opr_res;
        default:        wb_out.wdata = main_data.opr_res;
      endcase
    end
  end

  assign unused_dmem = ^main_data.dmem_rdata;

  assign rf_we    = wb_out.we && !wb_stall;
  assign rf_waddr = wb_out.waddr;
  assign rf_wdata = wb_out.wdata;
  assign fwd_en   = wb_out.we;
  assign fwd_rd   = wb_out.waddr;
  assign fwd_data = wb_out.wdata;

  // A flushed retire is not counted.
  assign retire = main_valid && !wb_stall;

  always_comb begin
    instret_d = instret_q;
    if (retire && !flush) instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized bench for wb_stage against a queue-based model.
module tb_wb_stage;
  import mem_stage_pkg::*;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  mem_stage_out_t in_data;
  logic           wb_stall;
  logic           flush;
  logic           rf_we;
  logic [4:0]     rf_waddr;
  logic [31:0]    rf_wdata;
  logic           fwd_en;
  logic [4:0]     fwd_rd;
  logic [31:0]    fwd_data;
  logic [63:0]    instret;

  int unsigned vectors;
  int unsigned miscompares;

  mem_stage_out_t mq[$];
  logic           m_ready;
  logic [63:0]    m_instret;

  wb_stage #(.INSTRET_W(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wb_stall (wb_stall),
    .flush    (flush),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .fwd_en   (fwd_en),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data),
    .instret  (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_stage_out_t mk(input logic [4:0] rd, input logic en,
                                        input logic [1:0] sel, input logic [31:0] opr,
                                        input logic [31:0] lsu);
    mem_stage_out_t e;
    e.opr_res    = opr;
    e.dmem_rdata = $urandom;
    e.lsu_rdata  = lsu;
    e.rd         = rd;
    e.rf_en      = en;
    e.wb_sel     = sel;
    return e;
  endfunction

  function automatic mem_stage_out_t rnd();
    return mk(5'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ready   = 1'b1;
    m_instret = 64'd0;
  endtask

  // Head of the queue is the entry being written back; only loads use lsu_rdata.
  task automatic check_model();
    logic        we;
    logic [4:0]  rd;
    logic [31:0] val;
    we  = 1'b0;
    rd  = 5'd0;
    val = 32'd0;
    if (mq.size() > 0) begin
      rd  = mq[0].rd;
      val = (mq[0].wb_sel == 2'b01) ? mq[0].lsu_rdata : mq[0].opr_res;
      we  = mq[0].rf_en && (mq[0].rd != 5'd0);
    end
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("rf_we",    64'(rf_we),    64'(we && !wb_stall));
    chk("rf_waddr", 64'(rf_waddr), 64'(rd));
    chk("rf_wdata", 64'(rf_wdata), 64'(val));
    chk("fwd_en",   64'(fwd_en),   64'(we));
    chk("fwd_rd",   64'(fwd_rd),   64'(rd));
    chk("fwd_data", 64'(fwd_data), 64'(val));
    chk("instret",  instret,       m_instret);
  endtask

  task automatic model_step();
    logic accept;
    logic retire;
    accept = in_valid && m_ready;
    retire = (mq.size() > 0) && !wb_stall;
    if (flush) begin
      mq.delete();
    end else begin
      if (retire) begin
        void'(mq.pop_front());
        m_instret = m_instret + 64'd1;
      end
      if (accept) mq.push_back(in_data);
    end
    m_ready = (mq.size() < 2);
  endtask

  task automatic drive(input logic v, input mem_stage_out_t d, input logic st, input logic fl);
    in_valid = v;
    in_data  = d;
    wb_stall = st;
    flush    = fl;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    mem_stage_out_t e;
    mem_stage_out_t bb[4];
    logic [63:0]    base;
    int             sent;
    logic           acc;
    logic           st;

    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    in_data     = '0;
    wb_stall    = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
    model_reset();

    #2 rst = 1'b1;
    #1 check_model();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // Single load
    e    = mk(5'd5, 1'b1, 2'b01, 32'h0000_0000, 32'hDEAD_BEEF);
    base = m_instret;
    drive(1'b1, e, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("ld_we",    64'(rf_we),    64'd1);
    chk("ld_waddr", 64'(rf_waddr), 64'd5);
    chk("ld_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("ld_instret", instret, base + 64'd1);
    tick();

    // Write to x0 is suppressed but still retires
    e    = mk(5'd0, 1'b1, 2'b00, 32'h0000_1234, 32'h0);
    base = m_instret;
    drive(1'b1, e, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("x0_we",  64'(rf_we),  64'd0);
    chk("x0_fwd", 64'(fwd_en), 64'd0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("x0_instret", instret, base + 64'd1);
    tick();

    // Back-to-back with a two-cycle stall after the first entry
    for (int i = 0; i < 4; i++)
      bb[i] = mk(5'(i + 1), 1'b1, 2'(i % 3), 32'h100 + 32'(i), 32'h200 + 32'(i));
    base = m_instret;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      st = (c == 1 || c == 2);
      if (sent < 4) drive(1'b1, bb[sent], st, 1'b0);
      else          drive(1'b0, '0, st, 1'b0);
      if (c == 2) chk("bb_full_ready", 64'(in_ready), 64'd0);
      acc = (sent < 4) && m_ready;
      tick();
      if (acc) sent++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("bb_sent",    64'(sent), 64'd4);
    chk("bb_instret", instret,   base + 64'd4);
    tick();

    // Forwarding stays live while stalled
    e = mk(5'd7, 1'b1, 2'b00, 32'h0000_0010, 32'hFFFF_FFFF);
    drive(1'b1, e, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("st_fwd_en",   64'(fwd_en),   64'd1);
      chk("st_fwd_rd",   64'(fwd_rd),   64'd7);
      chk("st_fwd_data", 64'(fwd_data), 64'h10);
      chk("st_rf_we",    64'(rf_we),    64'd0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("st_release_we", 64'(rf_we), 64'd1);
    tick();

    // Flush with both entries full and a new entry offered
    base = m_instret;
    drive(1'b1, rnd(), 1'b1, 1'b0);
    tick();
    drive(1'b1, rnd(), 1'b1, 1'b0);
    tick();
    drive(1'b1, rnd(), 1'b0, 1'b1);
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fl_ready",   64'(in_ready), 64'd1);
    chk("fl_we",      64'(rf_we),    64'd0);
    chk("fl_fwd",     64'(fwd_en),   64'd0);
    chk("fl_instret", instret,       base);
    tick();

    // Flush beats a simultaneous accept and retire
    base = m_instret;
    drive(1'b1, mk(5'd3, 1'b1, 2'b00, 32'h33, 32'h0), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(5'd4, 1'b1, 2'b00, 32'h44, 32'h0), 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fl2_fwd",     64'(fwd_en), 64'd0);
    chk("fl2_instret", instret,     base);
    tick();

    // Async reset mid-cycle with both entries full
    drive(1'b1, mk(5'd1, 1'b1, 2'b00, 32'h1, 32'h0), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(5'd2, 1'b1, 2'b00, 32'h2, 32'h0), 1'b1, 1'b0);
    tick();
    drive(1'b1, mk(5'd3, 1'b1, 2'b00, 32'h3, 32'h0), 1'b1, 1'b0);
    wb_stall = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rs_we",      64'(rf_we),    64'd0);
    chk("rs_fwd",     64'(fwd_en),   64'd0);
    chk("rs_waddr",   64'(rf_waddr), 64'd0);
    chk("rs_wdata",   64'(rf_wdata), 64'd0);
    chk("rs_fwddata", 64'(fwd_data), 64'd0);
    chk("rs_ready",   64'(in_ready), 64'd1);
    chk("rs_instret", instret,       64'd0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
